// File: rtl/kbd_rx_ctrl.sv
// kbd_rx_ctrl: host-side receiver for the 2-wire keyboard link.
// It deglitches the link, checks each frame and queues good bytes in a FIFO; it inhibits the device when the FIFO is full.
module kbd_rx_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 2000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          kbd_clk,
    input  logic                          kbd_dat,
    output logic                          inhibit,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          err_overflow,
    output logic                          err_timeout
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic filt_clk, filt_prev;
    logic [FW-1:0] filt_cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic par;
    logic [TW-1:0] tcnt;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic fall, bit_in, full, pop, stop_ev, good, push;

    assign fall     = filt_prev & ~filt_clk;
    assign bit_in   = dat_sync[SYNC_STAGES-1];
    assign full     = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign rx_valid = fifo_count != '0;
    assign rx_data  = mem[rd_ptr];
    assign pop      = rx_valid & rx_ready;
    assign stop_ev  = fall & (state == STOP);
    assign good     = stop_ev & bit_in & ^{shreg, par};
    assign push     = good & (~full | pop);

    // Sync and filter state preset high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            dat_sync  <= '1;
            filt_clk  <= 1'b1;
            filt_prev <= 1'b1;
            filt_cnt  <= '0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbd_clk};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], kbd_dat};
            filt_prev <= filt_clk;
            if (clk_sync[SYNC_STAGES-1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[SYNC_STAGES-1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            shreg        <= '0;
            par          <= 1'b0;
            tcnt         <= '0;
            inhibit      <= 1'b0;
            err_parity   <= 1'b0;
            err_frame    <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_parity   <= stop_ev & bit_in & ~^{shreg, par};
            err_frame    <= stop_ev & ~bit_in;
            err_overflow <= good & full & ~pop;
            err_timeout  <= 1'b0;
            inhibit      <= full & (state == IDLE);
            tcnt         <= (state == IDLE || fall) ? '0 : tcnt + 1'b1;
            if (fall) begin
                case (state)
                    IDLE: begin
                        state <= bit_in ? IDLE : DATA;
                        idx   <= '0;
                    end
                    DATA: begin
                        shreg[idx] <= bit_in;
                        idx        <= idx + 1'b1;
                        if (idx == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= bit_in;
                        state <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYC - 1)) begin
                err_timeout <= 1'b1;
                state       <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// tb_kbd_rx_ctrl: directed frames on the keyboard link.
// Received bytes and error pulses are checked against an expected-byte queue and expected error counts.
`timescale 1ns/1ps
module tb_kbd_rx_ctrl;
    logic clk = 0, reset = 1, kbd_clk = 1, kbd_dat = 1, rx_ready = 0;
    logic inhibit, rx_valid, err_parity, err_frame, err_overflow, err_timeout;
    logic [7:0] rx_data;
    logic [2:0] fifo_count;
    int vectors = 0, miscompares = 0;
    int n_par = 0, n_frm = 0, n_ovf = 0, n_to = 0;
    int e_par = 0, e_frm = 0, e_ovf = 0, e_to = 0;
    logic [7:0] exp_q[$];

    kbd_rx_ctrl dut (
        .clk(clk), .reset(reset), .kbd_clk(kbd_clk), .kbd_dat(kbd_dat),
        .inhibit(inhibit), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_count(fifo_count), .err_parity(err_parity), .err_frame(err_frame),
        .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    always #500 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (err_parity) n_par++;
            if (err_frame) n_frm++;
            if (err_overflow) n_ovf++;
            if (err_timeout) n_to++;
            if (err_parity | err_frame | err_overflow | err_timeout)
                check("one_err_per_cycle", int'(err_parity) + int'(err_frame) + int'(err_overflow) + int'(err_timeout), 1);
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_byte: got %0d, expected none", rx_data);
                end else begin
                    check("rx_data", rx_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input int glitch);
        kbd_dat = b;
        tick(10);
        if (glitch > 0) begin
            kbd_clk = 0;
            tick(glitch);
            kbd_clk = 1;
            tick(10 - glitch);
        end else begin
            tick(10);
        end
        kbd_clk = 0;
        tick(40);
        kbd_clk = 1;
        tick(20);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_inv, input logic stop, input int nbits, input int glitch);
        logic [10:0] f;
        f = {stop, ~^d ^ par_inv, d, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_par"}, n_par, e_par);
        check({tag, "_frm"}, n_frm, e_frm);
        check({tag, "_ovf"}, n_ovf, e_ovf);
        check({tag, "_to"}, n_to, e_to);
    endtask

    initial begin
        tick(5);
        check("rst_valid", rx_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_inhibit", inhibit, 0);
        check("rst_data", rx_data, 0);
        check("rst_errs", {err_parity, err_frame, err_overflow, err_timeout}, 0);
        reset = 0;
        rx_ready = 1;
        tick(5);
        check("no_fall_after_reset", fifo_count, 0);
        for (int d = 0; d < 16; d++) begin
            exp_q.push_back(8'(d));
            send_frame(8'(d), 0, 1, 11, 0);
        end
        tick(10);
        check("basic_drained", exp_q.size(), 0);
        check_errs("basic");
        e_par++;
        send_frame(8'hA5, 1, 1, 11, 0);
        tick(5);
        check("par_fifo_empty", fifo_count, 0);
        check_errs("parity");
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 0, 1, 11, 0);
        e_frm++;
        send_frame(8'h55, 0, 0, 11, 0);
        tick(5);
        check("frm_fifo_empty", fifo_count, 0);
        check_errs("frame");
        send_frame(8'hFF, 0, 1, 4, 0);
        kbd_dat = 1;
        e_to++;
        tick(2100);
        check_errs("timeout");
        exp_q.push_back(8'h12);
        send_frame(8'h12, 0, 1, 11, 0);
        tick(10);
        check("timeout_drained", exp_q.size(), 0);
        rx_ready = 0;
        for (int d = 1; d <= 5; d++) begin
            if (d <= 4) exp_q.push_back(8'(d));
            else e_ovf++;
            send_frame(8'(d), 0, 1, 11, 0);
            if (d == 1) check("ovf_count_1", fifo_count, 1);
            if (d == 4) begin
                check("ovf_inhibit_on", inhibit, 1);
                check("ovf_count_4", fifo_count, 4);
            end
        end
        check_errs("overflow");
        check("ovf_count_still_4", fifo_count, 4);
        rx_ready = 1;
        tick(3);
        check("inhibit_off_after_pop", inhibit, 0);
        tick(10);
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_count_0", fifo_count, 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0, 1, 11, 1);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 0, 1, 11, 2);
        tick(10);
        check("glitch_drained", exp_q.size(), 0);
        check_errs("glitch");
        rx_ready = 0;
        send_frame(8'h99, 0, 1, 11, 0);
        check("pre_reset_count", fifo_count, 1);
        send_frame(8'h33, 0, 1, 5, 0);
        reset = 1;
        tick(3);
        reset = 0;
        tick(1);
        check("post_reset_count", fifo_count, 0);
        check("post_reset_valid", rx_valid, 0);
        rx_ready = 1;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 0, 1, 11, 0);
        tick(10);
        check("reset_drained", exp_q.size(), 0);
        check_errs("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
